// File: rtl/rtport_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rtport_rr_arbiter
//   Round-robin arbiter that shares one RTPort output link among N_REQ
//   requesters (the router's input ports). Both sides use a registered
//   4-phase req/ack handshake. The winning packet is latched on the grant
//   edge and forwarded unchanged until the transfer completes.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous reset, active-high
//   req_i        per-source request (bit i = source i)
//   ack_i        per-source acknowledge, only the granted bit can be set
//   data_i       source i packet at [i*WIDTH +: WIDTH]
//   req_o        request to the shared output link
//   data_o       latched packet of the granted source
//   ack_o        acknowledge from the output link
//   grant_o      one-hot current grant, 0 when idle
//   busy_o       1 whenever the FSM is not idle
//   xfer_cnt_o   completed-transfer counter, wraps
// ---------------------------------------------------------------------------
module rtport_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 34,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_i,
   output logic [N_REQ-1:0]         ack_i,
   input  logic [N_REQ*WIDTH-1:0]   data_i,
   output logic                     req_o,
   output logic [WIDTH-1:0]         data_o,
   input  logic                     ack_o,
   output logic [N_REQ-1:0]         grant_o,
   output logic                     busy_o,
   output logic [CNT_W-1:0]         xfer_cnt_o
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_ACK  = 2'd2,
      ST_RTZ  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               req_q, req_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;

   // Arbitration candidates, valid only while idle
   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_off;
   logic [IDX_W:0]     pick_sum;
   logic [IDX_W-1:0]   pick_idx;
   logic [N_REQ-1:0]   pick_oh;
   logic [WIDTH-1:0]   pick_data;
   logic [IDX_W-1:0]   ptr_next;

   // Rotate requests so bit 0 is the highest-priority source, then find the
   // first set bit; the offset is added back to rr_ptr modulo N_REQ.
   always_comb begin
      req_dbl  = {req_i, req_i} >> rr_ptr_q;
      req_rot  = req_dbl[N_REQ-1:0];
      pick_vld = 1'b0;
      pick_off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            pick_vld = 1'b1;
            pick_off = IDX_W'(k);
         end
      end
      pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
      if (pick_sum >= (IDX_W + 1)'(N_REQ)) begin
         pick_sum = pick_sum - (IDX_W + 1)'(N_REQ);
      end
      pick_idx = pick_sum[IDX_W-1:0];
   end

   // One-hot grant and packet select for the chosen source
   always_comb begin
      pick_oh   = '0;
      pick_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_idx == IDX_W'(k)) begin
            pick_oh[k] = 1'b1;
            pick_data  = data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer moves past the last winner so it has lowest priority next
   always_comb begin
      if (gnt_idx_q == IDX_W'(N_REQ - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = gnt_idx_q + IDX_W'(1);
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_idx_d = gnt_idx_q;
      grant_d   = grant_q;
      data_d    = data_q;
      req_d     = req_q;
      ack_d     = ack_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               gnt_idx_d = pick_idx;
               grant_d   = pick_oh;
               data_d    = pick_data;
               req_d     = 1'b1;
               state_d   = ST_FWD;
            end
         end
         ST_FWD: begin
            // A source dropping its request here is ignored; ACK exits next edge
            if (ack_o) begin
               ack_d   = grant_q;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if ((req_i & grant_q) == '0) begin
               req_d   = 1'b0;
               state_d = ST_RTZ;
            end
         end
         ST_RTZ: begin
            if (!ack_o) begin
               ack_d    = '0;
               grant_d  = '0;
               rr_ptr_d = ptr_next;
               cnt_d    = cnt_q + CNT_W'(1);
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         gnt_idx_q <= '0;
         grant_q   <= '0;
         data_q    <= '0;
         req_q     <= 1'b0;
         ack_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_idx_q <= gnt_idx_d;
         grant_q   <= grant_d;
         data_q    <= data_d;
         req_q     <= req_d;
         ack_q     <= ack_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
      end
   end

   assign ack_i      = ack_q;
   assign req_o      = req_q;
   assign data_o     = data_q;
   assign grant_o    = grant_q;
   assign busy_o     = busy_q;
   assign xfer_cnt_o = cnt_q;

endmodule

// File: tb/tb_rtport_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rtport_rr_arbiter
//   Drives both handshake sides of the arbiter and compares every registered
//   output against a transaction-level reference (priority scan from a
//   pointer, counter as plain integer arithmetic). A second instance with a
//   2-bit counter shares all inputs to observe counter wrap.
// ---------------------------------------------------------------------------
module tb_rtport_rr_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 34;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_i;
   logic [N-1:0]     ack_i;
   logic [N*W-1:0]   data_i;
   logic             req_o;
   logic [W-1:0]     data_o;
   logic             ack_o;
   logic [N-1:0]     grant_o;
   logic             busy_o;
   logic [15:0]      xfer_cnt_o;

   logic [N-1:0]     ack_i2;
   logic             req_o2;
   logic [W-1:0]     data_o2;
   logic [N-1:0]     grant_o2;
   logic             busy_o2;
   logic [1:0]       xfer_cnt_o2;

   int               n_tests;
   int               n_fail;

   // Reference state
   int               m_ptr;
   int               m_cnt;
   logic [W-1:0]     pkt [N];
   bit               fix_d0;
   logic [W-1:0]     fix_val;

   rtport_rr_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_W(16)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .ack_i      (ack_i),
      .data_i     (data_i),
      .req_o      (req_o),
      .data_o     (data_o),
      .ack_o      (ack_o),
      .grant_o    (grant_o),
      .busy_o     (busy_o),
      .xfer_cnt_o (xfer_cnt_o)
   );

   rtport_rr_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_W(2)) u_dut_c2 (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .ack_i      (ack_i2),
      .data_i     (data_i),
      .req_o      (req_o2),
      .data_o     (data_o2),
      .ack_o      (ack_o),
      .grant_o    (grant_o2),
      .busy_o     (busy_o2),
      .xfer_cnt_o (xfer_cnt_o2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick(input logic [N-1:0] pat);
      for (int k = 0; k < int'(N); k++) begin
         if (pat[(m_ptr + k) % int'(N)]) return (m_ptr + k) % int'(N);
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] rand_pkt();
      return W'({$urandom(), $urandom()});
   endfunction

   task automatic load_pkts();
      for (int k = 0; k < int'(N); k++) data_i[k*W +: W] = pkt[k];
   endtask

   task automatic scramble_data();
      for (int k = 0; k < int'(N); k++) data_i[k*W +: W] = rand_pkt();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " req_o"},   64'(req_o),   64'd0);
      check({tag, " ack_i"},   64'(ack_i),   64'd0);
      check({tag, " grant_o"}, 64'(grant_o), 64'd0);
      check({tag, " busy_o"},  64'(busy_o),  64'd0);
      check({tag, " data_o"},  64'(data_o),  64'd0);
      check({tag, " cnt"},     64'(xfer_cnt_o),  64'd0);
      check({tag, " cnt2"},    64'(xfer_cnt_o2), 64'd0);
   endtask

   task automatic apply_reset(input int cycles);
      rst   = 1'b1;
      req_i = '0;
      ack_o = 1'b0;
      for (int c = 0; c < cycles; c++) step();
      check_all_zero("reset");
      rst   = 1'b0;
      m_ptr = 0;
      m_cnt = 0;
   endtask

   // Full transfer: grant, fwd_wait cycles of backpressure, ack, ack_hold
   // cycles in ACK, drop, rtz_hold cycles in RTZ, release. With viol set the
   // winner drops its request before being acknowledged. exp_g >= 0 adds an
   // absolute check of the winner.
   task automatic do_xfer(input logic [N-1:0] pat, input int fwd_wait, input int ack_hold,
                          input int rtz_hold, input bit viol, input int exp_g);
      int           g;
      logic [W-1:0] exp_data;
      logic [N-1:0] oh;
      int           ah;

      for (int k = 0; k < int'(N); k++) pkt[k] = rand_pkt();
      if (fix_d0) pkt[0] = fix_val;
      load_pkts();
      req_i = pat;
      ack_o = 1'b0;
      g        = model_pick(pat);
      exp_data = pkt[g];
      oh       = N'(1) << g;
      ah       = viol ? 0 : ack_hold;

      step();
      check("grant req_o",   64'(req_o),   64'd1);
      check("grant grant_o", 64'(grant_o), 64'(oh));
      check("grant data_o",  64'(data_o),  64'(exp_data));
      check("grant busy_o",  64'(busy_o),  64'd1);
      check("grant ack_i",   64'(ack_i),   64'd0);
      check("grant c2",      64'(grant_o2), 64'(oh));
      if (exp_g >= 0) check("abs winner", 64'(grant_o), 64'(N'(1) << exp_g));

      for (int c = 0; c < fwd_wait; c++) begin
         scramble_data();
         req_i    = N'($urandom_range(0, (1 << N) - 1));
         req_i[g] = ~viol;
         step();
         check("fwd req_o",   64'(req_o),   64'd1);
         check("fwd data_o",  64'(data_o),  64'(exp_data));
         check("fwd ack_i",   64'(ack_i),   64'd0);
         check("fwd grant_o", 64'(grant_o), 64'(oh));
      end

      req_i[g] = ~viol;
      ack_o    = 1'b1;
      step();
      check("ack ack_i",  64'(ack_i),  64'(oh));
      check("ack req_o",  64'(req_o),  64'd1);
      check("ack data_o", 64'(data_o), 64'(exp_data));

      for (int c = 0; c < ah; c++) begin
         req_i    = N'($urandom_range(0, (1 << N) - 1));
         req_i[g] = 1'b1;
         step();
         check("ackh ack_i", 64'(ack_i), 64'(oh));
         check("ackh req_o", 64'(req_o), 64'd1);
      end

      req_i    = N'($urandom_range(0, (1 << N) - 1));
      req_i[g] = 1'b0;
      step();
      check("drop req_o",   64'(req_o),   64'd0);
      check("drop ack_i",   64'(ack_i),   64'(oh));
      check("drop busy_o",  64'(busy_o),  64'd1);
      check("drop grant_o", 64'(grant_o), 64'(oh));

      for (int c = 0; c < rtz_hold; c++) begin
         req_i = N'($urandom_range(0, (1 << N) - 1));
         step();
         check("rtz ack_i", 64'(ack_i), 64'(oh));
         check("rtz req_o", 64'(req_o), 64'd0);
      end

      ack_o = 1'b0;
      step();
      m_cnt = m_cnt + 1;
      m_ptr = (g + 1) % int'(N);
      check("done ack_i",   64'(ack_i),   64'd0);
      check("done grant_o", 64'(grant_o), 64'd0);
      check("done busy_o",  64'(busy_o),  64'd0);
      check("done req_o",   64'(req_o),   64'd0);
      check("done data_o",  64'(data_o),  64'(exp_data));
      check("done cnt",     64'(xfer_cnt_o),  64'(m_cnt % 65536));
      check("done cnt2",    64'(xfer_cnt_o2), 64'(m_cnt % 4));
      req_i = '0;
   endtask

   // Idle cycles with no requests; ack_o toggled freely must not start anything
   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         req_i = '0;
         ack_o = $urandom_range(0, 1) != 0;
         step();
         check("idle busy_o",  64'(busy_o),  64'd0);
         check("idle req_o",   64'(req_o),   64'd0);
         check("idle ack_i",   64'(ack_i),   64'd0);
         check("idle grant_o", 64'(grant_o), 64'd0);
      end
      ack_o = 1'b0;
   endtask

   initial begin
      logic [N-1:0] pat;
      int           g;
      n_tests = 0;
      n_fail  = 0;
      fix_d0  = 1'b0;
      fix_val = '0;
      rst     = 1'b1;
      req_i   = '0;
      ack_o   = 1'b0;
      data_i  = '0;

      apply_reset(3);

      // Single requester with a known packet
      fix_d0  = 1'b1;
      fix_val = 34'h2_DEADBEEF;
      do_xfer(4'b0001, 0, 1, 1, 1'b0, 0);
      fix_d0  = 1'b0;
      idle(2);

      // Round-robin rotation from reset with all sources requesting
      apply_reset(1);
      for (int i = 0; i < 5; i++) do_xfer(4'b1111, 0, 0, 0, 1'b0, i % 4);

      // Pointer wrap: source 2 wins, then 3 and 0 compete
      do_xfer(4'b0100, 0, 0, 0, 1'b0, 2);
      do_xfer(4'b1001, 0, 0, 0, 1'b0, 3);
      do_xfer(4'b1001, 0, 0, 0, 1'b0, 0);

      // Long backpressure
      do_xfer(4'b0010, 20, 2, 2, 1'b0, 1);

      // Winner drops request before acknowledge
      do_xfer(4'b0110, 2, 0, 1, 1'b1, 2);
      do_xfer(4'b1000, 0, 0, 0, 1'b1, 3);
      idle(3);

      // Reset while in ACK
      pat = 4'b0100;
      for (int k = 0; k < int'(N); k++) pkt[k] = rand_pkt();
      load_pkts();
      g     = model_pick(pat);
      req_i = pat;
      step();
      check("mid grant", 64'(grant_o), 64'(N'(1) << g));
      ack_o = 1'b1;
      step();
      check("mid ack_i", 64'(ack_i), 64'(N'(1) << g));
      rst = 1'b1;
      step();
      check_all_zero("midrst");
      rst   = 1'b0;
      m_ptr = 0;
      m_cnt = 0;
      req_i = '0;
      ack_o = 1'b0;
      step();
      check("post rst busy", 64'(busy_o), 64'd0);

      // Lowest index wins after reset; narrow counter goes 1,2,3,0,1
      do_xfer(4'b1010, 0, 0, 0, 1'b0, 1);
      do_xfer(4'b1111, 1, 0, 0, 1'b0, 2);
      do_xfer(4'b0011, 0, 1, 0, 1'b0, 0);
      do_xfer(4'b0011, 0, 0, 1, 1'b0, 1);
      do_xfer(4'b1100, 0, 0, 0, 1'b0, 2);

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         pat = N'($urandom_range(1, (1 << N) - 1));
         do_xfer(pat, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, -1);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard time limit so the bench always terminates
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
